// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic MAC array feeders.
// B-row fetch FSM states and the signed element type live here.
package systolic_pkg;

   localparam int DEF_BITS_AB = 8;
   localparam int DEF_DIM     = 8;
   localparam int DEF_ADDR_W  = 16;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} bfetch_state_t;

   typedef logic signed [DEF_BITS_AB-1:0] elem_t;

endpackage

// File: rtl/b_row_assembler.sv
// Serial-to-parallel row buffer: collects DIM returning RAM elements into one row.
// The final element can be forwarded combinationally so a row leaves on the edge it completes.
module b_row_assembler
   import systolic_pkg::*;
#(
   parameter int BITS_AB = DEF_BITS_AB,
   parameter int DIM     = DEF_DIM
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      wr,
   input  logic signed [BITS_AB-1:0] wr_data,
   input  logic                      take,
   output logic                      full,
   output logic                      last_in,
   output logic                      avail,
   output logic signed [BITS_AB-1:0] row [DIM]
);

   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(DIM - 1);

   logic [CW-1:0]             col;
   logic signed [BITS_AB-1:0] slots [DIM];

   assign last_in = wr && (col == COL_MAX);
   assign avail   = full || last_in;

   always_comb begin
      row = slots;
      if (last_in) row[DIM-1] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col  <= '0;
         full <= 1'b0;
      end else if (clr) begin
         col  <= '0;
         full <= 1'b0;
      end else begin
         if (take) full <= 1'b0;
         if (wr) begin
            // A row completing without being taken parks here until the output frees up.
            if (col == COL_MAX) begin
               col  <= '0;
               full <= !take;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) slots[col] <= wr_data;
   end

endmodule

// File: rtl/b_row_fetch.sv
// Fetches a DIMxDIM signed B matrix from synchronous RAM row by row and presents
// each row over valid/ready, followed by DIM zero rows to drain the skew buffer.
module b_row_fetch
   import systolic_pkg::*;
#(
   parameter int BITS_AB = DEF_BITS_AB,
   parameter int DIM     = DEF_DIM,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   output logic                      busy,
   output logic                      done,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic signed [BITS_AB-1:0] mem_rdata,
   output logic                      row_valid,
   input  logic                      row_ready,
   output logic signed [BITS_AB-1:0] row_data [DIM],
   output logic                      row_last
);

   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int DW = $clog2(DIM + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(DIM - 1);
   localparam logic [DW-1:0] DRN_MAX = DW'(DIM - 1);
   localparam logic [DW-1:0] DRN_END = DW'(DIM);

   bfetch_state_t state, state_nx;

   logic                      start_acc;
   logic [CW-1:0]             rd_col, rd_row, mv_row;
   logic                      rd_fin;
   logic                      rd_vld_p1;
   logic [DW-1:0]             drn_cnt;
   logic                      out_free, take, drn_load;
   logic                      asm_full, asm_last_in, asm_avail;
   logic signed [BITS_AB-1:0] asm_row [DIM];

   b_row_assembler #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM)
   ) u_asm (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start_acc),
      .wr      (rd_vld_p1),
      .wr_data (mem_rdata),
      .take    (take),
      .full    (asm_full),
      .last_in (asm_last_in),
      .avail   (asm_avail),
      .row     (asm_row)
   );

   assign out_free = !row_valid || row_ready;
   assign take     = (state == FETCH) && asm_avail && out_free;
   assign drn_load = (state == DRAIN) && out_free && (drn_cnt != DRN_END);

   // A read is only issued when its element is sure to find a free slot on return.
   assign mem_rd_en = (state == FETCH) && !rd_fin && !asm_full &&
                      !(asm_last_in && !out_free);

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nx  = FETCH;
            end
         end
         FETCH: begin
            busy = 1'b1;
            if (take && (mv_row == COL_MAX)) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (row_valid && row_ready && row_last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Read issue stage: address/row/col counters, request valid carried to p1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_col    <= '0;
         rd_row    <= '0;
         rd_fin    <= 1'b0;
         rd_vld_p1 <= 1'b0;
         mem_addr  <= '0;
         mv_row    <= '0;
         drn_cnt   <= '0;
         row_valid <= 1'b0;
         row_last  <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_vld_p1 <= mem_rd_en;
         if (start_acc) begin
            mem_addr <= base_addr;
            rd_col   <= '0;
            rd_row   <= '0;
            rd_fin   <= 1'b0;
            mv_row   <= '0;
            drn_cnt  <= '0;
         end
         if (mem_rd_en) begin
            mem_addr <= mem_addr + 1'b1;
            if (rd_col == COL_MAX) begin
               rd_col <= '0;
               if (rd_row == COL_MAX) rd_fin <= 1'b1;
               else                   rd_row <= rd_row + 1'b1;
            end else begin
               rd_col <= rd_col + 1'b1;
            end
         end
         // Output stage: acceptance and refill on one edge keep row_valid high
         if (row_valid && row_ready) begin
            row_valid <= 1'b0;
            row_last  <= 1'b0;
         end
         if (take) begin
            row_valid <= 1'b1;
            mv_row    <= mv_row + 1'b1;
         end
         if (drn_load) begin
            row_valid <= 1'b1;
            row_last  <= (drn_cnt == DRN_MAX);
            drn_cnt   <= drn_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIM; i++) row_data[i] <= '0;
      end else if (take) begin
         row_data <= asm_row;
      end else if (drn_load) begin
         for (int i = 0; i < DIM; i++) row_data[i] <= '0;
      end
   end

endmodule
